// File: rtl/hrange_vec.sv
// hrange_vec: signed range generator emitting LANES values per beat with a keep mask.
module hrange_vec #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic [WIDTH-1:0]        lo,
  input  logic [WIDTH-1:0]        hi,
  input  logic [WIDTH-1:0]        step,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic [LANES*WIDTH-1:0]  _out,
  output logic [LANES-1:0]        _keep
);
  localparam int EW = WIDTH + $clog2(LANES) + 1;
  typedef enum logic {DONE, RUN} state_t;
  state_t r_state;
  logic signed [EW-1:0] r_i, r_hi, r_step, w_next;
  logic [LANES*WIDTH-1:0] w_out;
  logic [LANES-1:0] w_keep;
  logic w_pos, w_neg, w_next_ok, w_emit;
  assign w_neg = r_step[EW-1];
  assign w_pos = !r_step[EW-1] && |r_step;
  assign w_next = r_i + EW'(LANES) * r_step;
  assign w_next_ok = w_pos ? (w_next < r_hi) : (w_neg && w_next > r_hi);
  assign w_emit = !_valid || _ready;
  assign _done = (r_state == DONE) && !_valid;
  // Wide arithmetic keeps out-of-WIDTH values comparable, so they always fail against hi.
  always_comb begin
    logic signed [EW-1:0] v;
    v = '0;
    w_keep = '0;
    w_out = '0;
    for (int c = 0; c < LANES; c++) begin
      v = r_i + EW'(c) * r_step;
      w_keep[c] = (w_pos && v < r_hi) || (w_neg && v > r_hi);
      w_out[c*WIDTH +: WIDTH] = w_keep[c] ? v[WIDTH-1:0] : '0;
    end
  end
  always_ff @(posedge _clock) begin
    if (_start) begin
      r_i <= {{(EW-WIDTH){lo[WIDTH-1]}}, lo};
      r_hi <= {{(EW-WIDTH){hi[WIDTH-1]}}, hi};
      r_step <= {{(EW-WIDTH){step[WIDTH-1]}}, step};
      _valid <= 1'b0;
      r_state <= RUN;
    end else if (_reset) begin
      r_state <= DONE;
      _valid <= 1'b0;
      _keep <= '0;
      _out <= '0;
    end else if (r_state == RUN) begin
      if (w_emit && w_keep[0]) begin
        _out <= w_out;
        _keep <= w_keep;
        _valid <= 1'b1;
        r_i <= w_next;
        if (!(&w_keep) || !w_next_ok) r_state <= DONE;
      end else if (w_emit) begin
        _valid <= 1'b0;
        r_state <= DONE;
      end
    end else if (_ready) begin
      _valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hrange_vec.sv
// tb_hrange_vec: scoreboard bench over LANES=1/4 (WIDTH=32) and LANES=2 (WIDTH=8) instances.
module tb_hrange_vec;
  typedef logic [131:0] exp_t;
  logic clk = 1'b0;
  logic rst, rdy, st1, st2, st4;
  logic [31:0] lo, hi, step;
  logic v1, v2, v4, dn1, dn2, dn4;
  logic [31:0] o1;
  logic [15:0] o2;
  logic [127:0] o4;
  logic [0:0] k1;
  logic [1:0] k2;
  logic [3:0] k4;
  exp_t q1[$], q2[$], q4[$];
  exp_t e1g, e2g, e4g, e1x, e2x, e4x;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  hrange_vec #(.WIDTH(32), .LANES(1)) d1 (._clock(clk), ._reset(rst), ._start(st1), .lo(lo), .hi(hi),
    .step(step), ._ready(rdy), ._valid(v1), ._done(dn1), ._out(o1), ._keep(k1));
  hrange_vec #(.WIDTH(8), .LANES(2)) d2 (._clock(clk), ._reset(rst), ._start(st2), .lo(lo[7:0]), .hi(hi[7:0]),
    .step(step[7:0]), ._ready(rdy), ._valid(v2), ._done(dn2), ._out(o2), ._keep(k2));
  hrange_vec #(.WIDTH(32), .LANES(4)) d4 (._clock(clk), ._reset(rst), ._start(st4), .lo(lo), .hi(hi),
    .step(step), ._ready(rdy), ._valid(v4), ._done(dn4), ._out(o4), ._keep(k4));
  function automatic exp_t x1(input logic [31:0] v);
    return {4'b0001, 96'b0, v};
  endfunction
  function automatic exp_t x2(input logic [7:0] a, input logic [7:0] b, input logic [1:0] k);
    return {2'b0, k, 112'b0, b, a};
  endfunction
  function automatic exp_t x4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d, input logic [3:0] k);
    return {k, d, c, b, a};
  endfunction
  always @(negedge clk) begin
    if (v1 && rdy) begin
      total++;
      e1g = {4'(k1), 128'(o1)};
      if (q1.size() == 0) begin bad++; $display("FAIL d1 beat: got %h, none expected", e1g); end
      else begin
        e1x = q1.pop_front();
        if (e1g !== e1x) begin bad++; $display("FAIL d1 beat: got %h want %h", e1g, e1x); end
      end
    end
    if (v2 && rdy) begin
      total++;
      e2g = {4'(k2), 128'(o2)};
      if (q2.size() == 0) begin bad++; $display("FAIL d2 beat: got %h, none expected", e2g); end
      else begin
        e2x = q2.pop_front();
        if (e2g !== e2x) begin bad++; $display("FAIL d2 beat: got %h want %h", e2g, e2x); end
      end
    end
    if (v4 && rdy) begin
      total++;
      e4g = {k4, o4};
      if (q4.size() == 0) begin bad++; $display("FAIL d4 beat: got %h, none expected", e4g); end
      else begin
        e4x = q4.pop_front();
        if (e4g !== e4x) begin bad++; $display("FAIL d4 beat: got %h want %h", e4g, e4x); end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] x);
    total++;
    if (a !== x) begin bad++; $display("FAIL %s: got %0h want %0h", n, a, x); end
  endtask
  task automatic go(input int d, input logic [31:0] l, input logic [31:0] h, input logic [31:0] s);
    lo = l; hi = h; step = s;
    st1 = (d == 1); st2 = (d == 2); st4 = (d == 4);
    tick();
    st1 = 0; st2 = 0; st4 = 0;
  endtask
  task automatic wait_done(input int d, input string n);
    int k = 0;
    while (!(d == 1 ? dn1 : d == 2 ? dn2 : dn4) && k < 60) begin tick(); k++; end
    chk(n, d == 1 ? dn1 : d == 2 ? dn2 : dn4, 1);
  endtask
  initial begin
    rst = 1; rdy = 1; st1 = 0; st2 = 0; st4 = 0; lo = 0; hi = 0; step = 0;
    tick(); tick();
    rst = 0;
    chk("reset valid", v4, 0);
    chk("reset done", dn4, 1);
    chk("reset out", o4, 0);
    chk("reset keep", k4, 0);
    chk("reset done d1/d2", {dn1, dn2}, 2'b11);
    for (int i = 0; i < 10; i++) q1.push_back(x1(i));
    go(1, 0, 10, 1);
    chk("d1 start-cycle valid", v1, 0);
    tick();
    chk("d1 first-beat latency", v1, 1);
    for (int i = 0; i < 9; i++) tick();
    chk("d1 not done before last accept", dn1, 0);
    tick();
    chk("d1 done after beat 9", dn1, 1);
    chk("d1 queue drained", q1.size(), 0);
    q4.push_back(x4(0, 1, 2, 3, 4'b1111));
    q4.push_back(x4(4, 5, 6, 7, 4'b1111));
    q4.push_back(x4(8, 9, 0, 0, 4'b0011));
    go(4, 0, 10, 1);
    wait_done(4, "d4 up done");
    chk("d4 up drained", q4.size(), 0);
    q4.push_back(x4(10, 7, 4, 1, 4'b1111));
    go(4, 10, 0, -3);
    tick();
    chk("d4 down beat valid", v4, 1);
    tick();
    chk("d4 down done after one beat", dn4, 1);
    chk("d4 down drained", q4.size(), 0);
    go(4, 5, 5, 1);
    chk("empty done low in run", dn4, 0);
    tick();
    chk("empty done by T+2", dn4, 1);
    chk("empty no valid", v4, 0);
    go(4, 0, 10, 0);
    tick();
    chk("step0 done by T+2", dn4, 1);
    chk("step0 no valid", v4, 0);
    q2.push_back(x2(0, 1, 2'b11));
    q2.push_back(x2(2, 3, 2'b11));
    q2.push_back(x2(4, 5, 2'b11));
    q2.push_back(x2(6, 7, 2'b11));
    begin
      int k = 0;
      go(2, 0, 8, 1);
      while (!dn2 && k < 100) begin rdy = 1'($urandom_range(0, 1)); tick(); k++; end
      rdy = 1;
      chk("d2 backpressure done", dn2, 1);
      chk("d2 backpressure drained", q2.size(), 0);
    end
    q4.push_back(x4(0, 1, 2, 3, 4'b1111));
    q4.push_back(x4(4, 5, 6, 7, 4'b1111));
    go(4, 0, 100, 1);
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid reset valid", v4, 0);
    chk("mid reset done", dn4, 1);
    chk("mid reset out", o4, 0);
    chk("mid reset keep", k4, 0);
    chk("mid reset drained", q4.size(), 0);
    q4.push_back(x4(20, 21, 0, 0, 4'b0011));
    rst = 1;
    go(4, 20, 22, 1);
    rst = 0;
    chk("start over reset running", dn4, 0);
    wait_done(4, "start over reset done");
    chk("start over reset drained", q4.size(), 0);
    q2.push_back(x2(120, 125, 2'b11));
    go(2, 120, 127, 5);
    wait_done(2, "d2 width8 done");
    chk("d2 width8 drained", q2.size(), 0);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
